// File: rtl/e203_wbck_pkg.sv
// Shared types and default sizes for the integer regfile writeback path.
package e203_wbck_pkg;

  localparam int WBCK_XLEN        = 32;
  localparam int WBCK_RFIDX_WIDTH = 5;
  localparam int WBCK_STARVE_MAX  = 4;

  typedef struct packed {
    logic [WBCK_RFIDX_WIDTH-1:0] rdidx;
    logic [WBCK_XLEN-1:0]        wdat;
  } wbck_req_t;

endpackage

// File: rtl/e203_wbck_fifo.sv
// Synchronous FIFO of writeback requests; head is read straight from storage,
// so an entry pushed this cycle becomes visible at the head next cycle at the earliest.
module e203_wbck_fifo
  import e203_wbck_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  wbck_req_t                push_dat,
  input  logic                     pop,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   cnt,
  output wbck_req_t                head
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  wbck_req_t     r_mem [DEPTH];
  logic [AW-1:0] r_wptr;
  logic [AW-1:0] r_rptr;
  logic [AW:0]   r_cnt;
  logic          w_push;
  logic          w_pop;

  assign full   = (r_cnt == FULL_CNT);
  assign empty  = (r_cnt == {(AW+1){1'b0}});
  assign w_push = push & ~full;
  assign w_pop  = pop & ~empty;
  assign cnt    = r_cnt;
  assign head   = r_mem[r_rptr];

  // Storage needs no reset: occupancy alone decides what is valid.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wptr] <= push_dat;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_wptr <= {AW{1'b0}};
      r_rptr <= {AW{1'b0}};
      r_cnt  <= {(AW+1){1'b0}};
    end else begin
      if (w_push) begin
        r_wptr <= r_wptr + AW'(1'b1);
      end
      if (w_pop) begin
        r_rptr <= r_rptr + AW'(1'b1);
      end
      case ({w_push, w_pop})
        2'b10:   r_cnt <= r_cnt + (AW+1)'(1'b1);
        2'b01:   r_cnt <= r_cnt - (AW+1)'(1'b1);
        default: r_cnt <= r_cnt;
      endcase
    end
  end

endmodule

// File: rtl/e203_exu_wbck_arb.sv
// Regfile writeback arbiter: ALU results win by default, buffered long-pipe
// results are forced through after STARVE_MAX consecutive ALU wins.
module e203_exu_wbck_arb
  import e203_wbck_pkg::*;
#(
  parameter int XLEN        = WBCK_XLEN,
  parameter int RFIDX_WIDTH = WBCK_RFIDX_WIDTH,
  parameter int LONGP_DEPTH = 2,
  parameter int STARVE_MAX  = WBCK_STARVE_MAX
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         alu_wbck_i_valid,
  output logic                         alu_wbck_i_ready,
  input  logic [XLEN-1:0]              alu_wbck_i_wdat,
  input  logic [RFIDX_WIDTH-1:0]       alu_wbck_i_rdidx,
  input  logic                         longp_wbck_i_valid,
  output logic                         longp_wbck_i_ready,
  input  logic [XLEN-1:0]              longp_wbck_i_wdat,
  input  logic [RFIDX_WIDTH-1:0]       longp_wbck_i_rdidx,
  output logic                         wbck_dest_wen,
  output logic [RFIDX_WIDTH-1:0]       wbck_dest_idx,
  output logic [XLEN-1:0]              wbck_dest_dat,
  output logic [$clog2(LONGP_DEPTH):0] longp_cnt
);

  localparam int SW = $clog2(STARVE_MAX + 1);
  localparam logic [SW-1:0] STARVE_LIM = SW'(STARVE_MAX);

  wbck_req_t        w_alu_req;
  wbck_req_t        w_lp_req;
  wbck_req_t        w_head;
  wbck_req_t        w_sel;
  logic             w_full;
  logic             w_empty;
  logic             w_head_valid;
  logic             w_force_lp;
  logic             w_alu_grant;
  logic             w_lp_grant;
  logic [SW-1:0]    r_starve;
  logic             r_wen;
  logic [RFIDX_WIDTH-1:0] r_idx;
  logic [XLEN-1:0]  r_dat;

  assign w_alu_req = '{rdidx: alu_wbck_i_rdidx, wdat: alu_wbck_i_wdat};
  assign w_lp_req  = '{rdidx: longp_wbck_i_rdidx, wdat: longp_wbck_i_wdat};

  e203_wbck_fifo #(.DEPTH(LONGP_DEPTH)) u_longp_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .push     (longp_wbck_i_valid & ~w_full),
    .push_dat (w_lp_req),
    .pop      (w_lp_grant),
    .full     (w_full),
    .empty    (w_empty),
    .cnt      (longp_cnt),
    .head     (w_head)
  );

  // ALU ready is a function of buffer state only, never of ALU valid.
  assign w_head_valid       = ~w_empty;
  assign w_force_lp         = w_head_valid & (r_starve == STARVE_LIM);
  assign alu_wbck_i_ready   = ~w_force_lp;
  assign longp_wbck_i_ready = ~w_full;
  assign w_alu_grant        = ~w_force_lp & alu_wbck_i_valid;
  assign w_lp_grant         = w_head_valid & (w_force_lp | ~alu_wbck_i_valid);

  always_comb begin
    w_sel = w_head;
    if (w_alu_grant) begin
      w_sel = w_alu_req;
    end else begin
      w_sel = w_head;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_starve <= {SW{1'b0}};
    end else if (w_empty | w_lp_grant) begin
      r_starve <= {SW{1'b0}};
    end else if (w_alu_grant & (r_starve != STARVE_LIM)) begin
      r_starve <= r_starve + SW'(1'b1);
    end else begin
      r_starve <= r_starve;
    end
  end

  // x0 results still complete their handshake but never write the regfile.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_wen <= 1'b0;
      r_idx <= {RFIDX_WIDTH{1'b0}};
      r_dat <= {XLEN{1'b0}};
    end else if (w_alu_grant | w_lp_grant) begin
      r_wen <= (w_sel.rdidx != {RFIDX_WIDTH{1'b0}});
      r_idx <= w_sel.rdidx;
      r_dat <= w_sel.wdat;
    end else begin
      r_wen <= 1'b0;
    end
  end

  assign wbck_dest_wen = r_wen;
  assign wbck_dest_idx = r_idx;
  assign wbck_dest_dat = r_dat;

endmodule

// File: tb/tb_e203_exu_wbck_arb.sv
// Bench for the writeback arbiter: directed scenarios plus random traffic,
// all checked against a queue-based model of the arbitration rules.
module tb_e203_exu_wbck_arb;

  localparam int XLEN  = 32;
  localparam int RFW   = 5;
  localparam int DEPTH = 2;
  localparam int SMAX  = 4;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            alu_v;
  logic            alu_rdy;
  logic [XLEN-1:0] alu_dat;
  logic [RFW-1:0]  alu_idx;
  logic            lp_v;
  logic            lp_rdy;
  logic [XLEN-1:0] lp_dat;
  logic [RFW-1:0]  lp_idx;
  logic            wen;
  logic [RFW-1:0]  widx;
  logic [XLEN-1:0] wdat;
  logic [CW-1:0]   lcnt;

  always #5 clk = ~clk;

  e203_exu_wbck_arb #(.XLEN(XLEN), .RFIDX_WIDTH(RFW), .LONGP_DEPTH(DEPTH), .STARVE_MAX(SMAX)) dut (
    .clk(clk), .rst_n(rst_n),
    .alu_wbck_i_valid(alu_v), .alu_wbck_i_ready(alu_rdy),
    .alu_wbck_i_wdat(alu_dat), .alu_wbck_i_rdidx(alu_idx),
    .longp_wbck_i_valid(lp_v), .longp_wbck_i_ready(lp_rdy),
    .longp_wbck_i_wdat(lp_dat), .longp_wbck_i_rdidx(lp_idx),
    .wbck_dest_wen(wen), .wbck_dest_idx(widx), .wbck_dest_dat(wdat),
    .longp_cnt(lcnt)
  );

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [RFW-1:0]  idx;
    logic [XLEN-1:0] dat;
  } ent_t;

  // Reference model state
  ent_t            q[$];
  int              starve;
  logic            exp_wen;
  logic [RFW-1:0]  exp_idx;
  logic [XLEN-1:0] exp_dat;
  logic            exp_alu_rdy;
  logic            exp_lp_rdy;
  logic            obs_alu_rdy;
  logic            obs_lp_rdy;

  // Advance one clock: sample readies, step the model, then settle past the edge.
  task automatic tick();
    ent_t h;
    bit   had;
    bit   force_lp;
    #2;
    obs_alu_rdy = alu_rdy;
    obs_lp_rdy  = lp_rdy;
    if (!rst_n) begin
      q.delete();
      starve  = 0;
      exp_wen = 1'b0;
      exp_idx = '0;
      exp_dat = '0;
    end else begin
      had         = (q.size() > 0);
      exp_lp_rdy  = (q.size() < DEPTH);
      force_lp    = had && (starve == SMAX);
      exp_alu_rdy = !force_lp;
      if (force_lp || (!alu_v && had)) begin
        h       = q.pop_front();
        exp_wen = (h.idx != 0);
        exp_idx = h.idx;
        exp_dat = h.dat;
        starve  = 0;
      end else if (alu_v) begin
        exp_wen = (alu_idx != 0);
        exp_idx = alu_idx;
        exp_dat = alu_dat;
        if (!had) starve = 0;
        else if (starve < SMAX) starve++;
      end else begin
        exp_wen = 1'b0;
        starve  = 0;
      end
      if (lp_v && exp_lp_rdy) q.push_back({lp_idx, lp_dat});
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; alu_v = 1'b0; alu_dat = '0; alu_idx = '0;
    lp_v = 1'b1; lp_idx = 5'd9; lp_dat = 32'h0BAD_F00D;
    tick();
    tick();
    checks++; if (wen !== 1'b0) begin errors++; $display("FAIL reset_wen: got %b want 0", wen); end
    checks++; if (widx !== 5'd0) begin errors++; $display("FAIL reset_idx: got %0d want 0", widx); end
    checks++; if (wdat !== 32'd0) begin errors++; $display("FAIL reset_dat: got %h want 0", wdat); end
    checks++; if (lcnt !== 2'd0) begin errors++; $display("FAIL reset_cnt: got %0d want 0", lcnt); end
    rst_n = 1'b1; lp_v = 1'b0;
    #1;
    checks++; if (alu_rdy !== 1'b1) begin errors++; $display("FAIL reset_alu_ready: got %b want 1", alu_rdy); end
  endtask

  task automatic test_alu_only();
    alu_v = 1'b1; alu_idx = 5'd5; alu_dat = 32'hDEAD_BEEF;
    tick();
    checks++; if (wen !== 1'b1 || widx !== 5'd5 || wdat !== 32'hDEAD_BEEF) begin
      errors++; $display("FAIL alu_write: got wen=%b idx=%0d dat=%h want 1/5/deadbeef", wen, widx, wdat); end
    alu_idx = 5'd0; alu_dat = 32'h0000_1234;
    tick();
    checks++; if (obs_alu_rdy !== 1'b1) begin errors++; $display("FAIL alu_x0_ready: got %b want 1", obs_alu_rdy); end
    checks++; if (wen !== 1'b0) begin errors++; $display("FAIL alu_x0_wen: got %b want 0", wen); end
    alu_v = 1'b0;
    tick();
    checks++; if (wen !== 1'b0) begin errors++; $display("FAIL alu_idle_wen: got %b want 0", wen); end
  endtask

  task automatic test_longp_only();
    alu_v = 1'b0;
    lp_v = 1'b1; lp_idx = 5'd1; lp_dat = 32'hA5A5_A5A5;
    tick();
    lp_v = 1'b0;
    checks++; if (wen !== 1'b0 || lcnt !== 2'd1) begin
      errors++; $display("FAIL lp_no_bypass: got wen=%b cnt=%0d want 0/1", wen, lcnt); end
    tick();
    checks++; if (wen !== 1'b1 || widx !== 5'd1 || wdat !== 32'hA5A5_A5A5) begin
      errors++; $display("FAIL lp_write: got wen=%b idx=%0d dat=%h want 1/1/a5a5a5a5", wen, widx, wdat); end
    lp_v = 1'b1; lp_idx = 5'd3; lp_dat = 32'h1111_1111;
    tick();
    lp_idx = 5'd7; lp_dat = 32'h2222_2222;
    tick();
    lp_v = 1'b0;
    checks++; if (wen !== 1'b1 || widx !== 5'd3 || wdat !== 32'h1111_1111) begin
      errors++; $display("FAIL lp_order_first: got wen=%b idx=%0d dat=%h want 1/3/11111111", wen, widx, wdat); end
    tick();
    checks++; if (wen !== 1'b1 || widx !== 5'd7 || wdat !== 32'h2222_2222) begin
      errors++; $display("FAIL lp_order_second: got wen=%b idx=%0d dat=%h want 1/7/22222222", wen, widx, wdat); end
    tick();
    checks++; if (lcnt !== 2'd0 || wen !== 1'b0) begin
      errors++; $display("FAIL lp_drained: got cnt=%0d wen=%b want 0/0", lcnt, wen); end
  endtask

  task automatic test_starvation();
    int zero_at = -1;
    int resumed = 0;
    alu_v = 1'b1; alu_idx = 5'd2; alu_dat = $urandom;
    lp_v = 1'b1; lp_idx = 5'd12; lp_dat = 32'hC0FF_EE00;
    tick();
    lp_v = 1'b0;
    for (int i = 0; i < 8; i++) begin
      alu_idx = 5'($urandom_range(1, 11)); alu_dat = $urandom;
      tick();
      if (obs_alu_rdy === 1'b0 && zero_at < 0) begin
        zero_at = i;
        checks++; if (wen !== 1'b1 || widx !== 5'd12 || wdat !== 32'hC0FF_EE00) begin
          errors++; $display("FAIL starve_lp_write: got wen=%b idx=%0d dat=%h want 1/12/c0ffee00", wen, widx, wdat); end
      end else if (zero_at >= 0 && obs_alu_rdy === 1'b1 && wen === 1'b1 && widx !== 5'd12) begin
        resumed++;
      end
      checks++; if (wen !== exp_wen || widx !== exp_idx || wdat !== exp_dat) begin
        errors++; $display("FAIL starve_out[%0d]: got %b/%0d/%h want %b/%0d/%h", i, wen, widx, wdat, exp_wen, exp_idx, exp_dat); end
    end
    checks++; if (zero_at != SMAX) begin errors++; $display("FAIL starve_alu_wins: got %0d want %0d", zero_at, SMAX); end
    checks++; if (resumed != 8 - SMAX - 1) begin errors++; $display("FAIL starve_resume: got %0d want %0d", resumed, 8 - SMAX - 1); end
    alu_v = 1'b0;
    tick();
  endtask

  task automatic test_backpressure();
    logic [RFW-1:0] ids [3];
    logic [RFW-1:0] seen[$];
    int n = 0;
    bit saw_full = 0;
    ids[0] = 5'd20; ids[1] = 5'd21; ids[2] = 5'd22;
    alu_v = 1'b1;
    for (int c = 0; c < 30; c++) begin
      alu_idx = 5'($urandom_range(1, 15)); alu_dat = $urandom;
      lp_v = (n < 3);
      lp_idx = ids[(n < 3) ? n : 2]; lp_dat = {27'd0, lp_idx};
      tick();
      if (n == 2 && !saw_full) begin
        saw_full = 1;
        checks++; if (obs_lp_rdy !== 1'b0) begin errors++; $display("FAIL bp_full_ready: got %b want 0", obs_lp_rdy); end
      end
      if (lp_v && obs_lp_rdy) n++;
      if (wen === 1'b1 && widx >= 5'd20) seen.push_back(widx);
      checks++; if (obs_lp_rdy !== exp_lp_rdy || obs_alu_rdy !== exp_alu_rdy) begin
        errors++; $display("FAIL bp_ready[%0d]: got lp=%b alu=%b want lp=%b alu=%b", c, obs_lp_rdy, obs_alu_rdy, exp_lp_rdy, exp_alu_rdy); end
      checks++; if (wen !== exp_wen || widx !== exp_idx || wdat !== exp_dat || lcnt !== CW'(q.size())) begin
        errors++; $display("FAIL bp_out[%0d]: got %b/%0d/%h/%0d want %b/%0d/%h/%0d", c, wen, widx, wdat, lcnt, exp_wen, exp_idx, exp_dat, q.size()); end
    end
    lp_v = 1'b0; alu_v = 1'b0;
    checks++; if (n != 3) begin errors++; $display("FAIL bp_accepts: got %0d want 3", n); end
    checks++; if (seen.size() != 3 || seen[0] !== 5'd20 || seen[1] !== 5'd21 || seen[2] !== 5'd22) begin
      errors++; $display("FAIL bp_order: got %0d lp writes want 20,21,22", seen.size()); end
    tick();
  endtask

  task automatic test_reset_mid();
    alu_v = 1'b1; alu_idx = 5'd3; alu_dat = 32'h3333_3333;
    lp_v = 1'b1; lp_idx = 5'd9; lp_dat = 32'h9999_9999;
    tick();
    lp_idx = 5'd10; lp_dat = 32'hAAAA_AAAA;
    tick();
    lp_v = 1'b0;
    checks++; if (lcnt !== 2'd2) begin errors++; $display("FAIL rm_buffered: got %0d want 2", lcnt); end
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1; alu_v = 1'b0;
    checks++; if (lcnt !== 2'd0 || wen !== 1'b0) begin
      errors++; $display("FAIL rm_cleared: got cnt=%0d wen=%b want 0/0", lcnt, wen); end
    for (int i = 0; i < 10; i++) begin
      tick();
      checks++; if (wen !== 1'b0 || lcnt !== 2'd0) begin
        errors++; $display("FAIL rm_no_write[%0d]: got wen=%b idx=%0d cnt=%0d want 0/-/0", i, wen, widx, lcnt); end
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      alu_v   = ($urandom_range(0, 3) != 0);
      alu_idx = 5'($urandom_range(0, 31)); alu_dat = $urandom;
      lp_v    = ($urandom_range(0, 2) == 0);
      lp_idx  = 5'($urandom_range(0, 31)); lp_dat = $urandom;
      tick();
      checks++; if (obs_lp_rdy !== exp_lp_rdy || obs_alu_rdy !== exp_alu_rdy) begin
        errors++; $display("FAIL rnd_ready[%0d]: got lp=%b alu=%b want lp=%b alu=%b", c, obs_lp_rdy, obs_alu_rdy, exp_lp_rdy, exp_alu_rdy); end
      checks++; if (wen !== exp_wen || widx !== exp_idx || wdat !== exp_dat) begin
        errors++; $display("FAIL rnd_out[%0d]: got %b/%0d/%h want %b/%0d/%h", c, wen, widx, wdat, exp_wen, exp_idx, exp_dat); end
      checks++; if (lcnt !== CW'(q.size())) begin
        errors++; $display("FAIL rnd_cnt[%0d]: got %0d want %0d", c, lcnt, q.size()); end
    end
    alu_v = 1'b0; lp_v = 1'b0;
  endtask

  initial begin
    test_reset();
    test_alu_only();
    test_longp_only();
    test_starvation();
    test_backpressure();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/e203_exu_wbck_arb.md
Name: e203_exu_wbck_arb

Overview:
Writeback arbiter and writer for the integer regfile write port (wbck_dest_wen/idx/dat). It merges single-cycle ALU results with out-of-order long-pipe results (div, load, AGU), arbitrates between them, and drives one registered regfile write per cycle. Long-pipe results are buffered in a small FIFO. A starvation counter ensures long-pipe results still drain under back-to-back ALU traffic.

Parameters:
XLEN, 32, data width of the regfile write port
RFIDX_WIDTH, 5, regfile index width
LONGP_DEPTH, 2, long-pipe buffer entries (power of 2, >=2)
STARVE_MAX, 4, consecutive ALU wins tolerated while long-pipe head waits (>=1)

Ports:
clk  in  1  clock
rst_n  in  1  reset, synchronous, active-low
alu_wbck_i_valid  in  1  ALU result valid
alu_wbck_i_ready  out  1  ALU result accepted
alu_wbck_i_wdat  in  XLEN  ALU result data
alu_wbck_i_rdidx  in  RFIDX_WIDTH  ALU destination index
longp_wbck_i_valid  in  1  long-pipe result valid
longp_wbck_i_ready  out  1  long-pipe result accepted into buffer
longp_wbck_i_wdat  in  XLEN  long-pipe result data
longp_wbck_i_rdidx  in  RFIDX_WIDTH  long-pipe destination index
wbck_dest_wen  out  1  regfile write enable (registered)
wbck_dest_idx  out  RFIDX_WIDTH  regfile write index (registered)
wbck_dest_dat  out  XLEN  regfile write data (registered)
longp_cnt  out  $clog2(LONGP_DEPTH)+1  buffer occupancy, for debug and commit logic

Behaviour:
- Clocking and reset: one clock, clk. Reset is synchronous, active-low, on rst_n, sampled at posedge clk.
- Reset values: wbck_dest_wen=0, wbck_dest_idx=0, wbck_dest_dat=0, buffer empty (longp_cnt=0), starvation counter=0.
- Reset mid-operation discards all buffered entries. No write is issued for them.
- Long-pipe buffer: longp_wbck_i_ready = ~full.
  - Ready depends on full only, so there is no push when full, even if a pop occurs in the same cycle.
  - Push on valid&ready.
  - No bypass: a pushed entry can be granted no earlier than the next cycle.
- Arbitration, evaluated every cycle:
  - force_lp = head_valid & (starve_cnt == STARVE_MAX).
  - If force_lp, the buffer head is granted and alu_wbck_i_ready=0.
  - Otherwise the ALU has priority: alu_wbck_i_ready=1, and the ALU is granted when alu_wbck_i_valid=1. If the ALU is not valid, the head is granted when head_valid=1.
  - alu_wbck_i_ready must not depend on alu_wbck_i_valid.
- Starvation counter:
  - Cleared when the head is granted or the buffer is empty.
  - Incremented (saturating at STARVE_MAX) when head_valid=1 and the ALU is granted.
- Output stage:
  - On a grant, the next cycle drives wbck_dest_idx and wbck_dest_dat from the granted source.
  - wbck_dest_wen=1 unless rdidx==0.
  - x0 writes are consumed (handshake completes, buffer pops) with wen=0.
  - With no grant, wen=0 and idx/dat hold their last values.
- Latency: ALU handshake to wen is 1 cycle. Long-pipe handshake to wen is at least 2 cycles.
- Ordering: long-pipe results leave in acceptance order. There is no ordering guarantee between ALU and long-pipe results; hazard tracking sits upstream.
- Full buffer plus pop in the same cycle: occupancy decrements. Ready rises the following cycle.

Decomposition:
- Package e203_wbck_pkg holds:
  - XLEN and RFIDX_WIDTH defaults.
  - typedef wbck_req_t, a packed struct {rdidx, wdat}.
  - The STARVE_MAX default.
- Sub-module e203_wbck_fifo: a synchronous FIFO of wbck_req_t with parameter DEPTH and ports push/pop/full/empty/cnt/head. It is instantiated once for the long-pipe buffer.

Test Plan:
- Reset: hold rst_n=0 for 2 cycles while longp pushes are attempted -> wen=0, idx=0, dat=0, longp_cnt=0; after release, alu_wbck_i_ready=1.
- ALU only: valid with rdidx=5, wdat=0xDEADBEEF -> next cycle wen=1, idx=5, dat=0xDEADBEEF. Then rdidx=0, wdat=0x1234 -> ready=1, next cycle wen=0.
- Longp only: push rdidx=1, wdat=0xA5A5A5A5 at cycle T -> wen=1, idx=1 at T+2. Push a second entry while the first is still buffered -> both written in acceptance order.
- Starvation: continuous ALU valid with a longp entry buffered, STARVE_MAX=4 -> 4 ALU writes, then alu_wbck_i_ready=0 for one cycle, the longp entry is written, then ALU resumes.
- Backpressure: 3 longp pushes on consecutive cycles with ALU always valid and DEPTH=2 -> longp_wbck_i_ready=0 after 2 accepts, rises the cycle after the first forced pop, and the third entry is accepted without loss.
- Reset mid-operation: 2 entries buffered, rst_n=0 for 1 cycle -> longp_cnt=0, and no write ever occurs for the dropped indices.
